// File: rtl/vram_responder.sv
`default_nettype none
// ============================================================================
//  vram_responder : two-bank frame-buffer RAM with a fixed 2-cycle read pipe,
//                   vsync-driven front/back swap and sticky protocol flags.
//  Revision       : 1.0
// ============================================================================
module vram_responder #(
  parameter int ADDR_W   = 26,
  parameter int DATA_W   = 8,
  parameter int BANK_BIT = 19,
  parameter int FB_DEPTH = 307200,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              vsync,
  input  logic              RE,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              err_clr,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  output logic              front_sel,
  output logic [7:0]        frame_cnt,
  output logic              coll_err,
  output logic              oob_err,
  output logic              proto_err
);

  localparam logic [BANK_BIT-1:0] C_DEPTH = BANK_BIT'(FB_DEPTH);

  // The data path below is built as exactly two register stages.
  if (RD_LAT != 2) begin : g_lat_check
    $error("vram_responder: RD_LAT must be 2");
  end

  logic [BANK_BIT-1:0] offset;
  logic                bank;
  logic                in_range;
  logic                wr_en;
  logic                rd_acc;
  logic                swap;
  logic                coll_set;
  logic                oob_set;
  logic                proto_set;
  logic                unused_addr_hi;

  logic [DATA_W-1:0] mem_q [0:1][0:FB_DEPTH-1];
  logic [DATA_W-1:0] rd_word_q;

  logic              rd_vld1_q, rd_vld1_d;
  logic              rd_oob1_q, rd_oob1_d;
  logic              rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              vsync_q,   vsync_d;
  logic              front_sel_q, front_sel_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              coll_err_q,  coll_err_d;
  logic              oob_err_q,   oob_err_d;
  logic              proto_err_q, proto_err_d;

  assign offset         = ADDR[BANK_BIT-1:0];
  assign bank           = ADDR[BANK_BIT];
  assign unused_addr_hi = ^ADDR[ADDR_W-1:BANK_BIT+1];
  assign in_range       = (offset < C_DEPTH);

  // A simultaneous RE/WE keeps the write and drops the read.
  assign wr_en     = WE && in_range;
  assign rd_acc    = RE && !WE;
  assign swap      = vsync && !vsync_q;
  assign coll_set  = WE && (bank == front_sel_q);
  assign oob_set   = (RE || WE) && !in_range;
  assign proto_set = RE && WE;

  // RAM contents survive reset, so this block carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[bank][offset] <= WDATA;
    end
    if (rd_acc && in_range) begin
      rd_word_q <= mem_q[bank][offset];
    end
  end

  always_comb begin
    rd_vld1_d   = rd_acc;
    rd_oob1_d   = !in_range;
    rvalid_d    = rd_vld1_q;
    rdata_d     = rdata_q;
    if (rd_vld1_q) begin
      rdata_d = rd_oob1_q ? '0 : rd_word_q;
    end
    vsync_d     = vsync;
    front_sel_d = front_sel_q ^ swap;
    frame_cnt_d = frame_cnt_q + {7'd0, swap};
    // Set has priority over a coincident clear.
    coll_err_d  = coll_set  | (coll_err_q  & ~err_clr);
    oob_err_d   = oob_set   | (oob_err_q   & ~err_clr);
    proto_err_d = proto_set | (proto_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rd_vld1_q   <= 1'b0;
      rd_oob1_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      vsync_q     <= 1'b0;
      front_sel_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      coll_err_q  <= 1'b0;
      oob_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rd_vld1_q   <= rd_vld1_d;
      rd_oob1_q   <= rd_oob1_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      vsync_q     <= vsync_d;
      front_sel_q <= front_sel_d;
      frame_cnt_q <= frame_cnt_d;
      coll_err_q  <= coll_err_d;
      oob_err_q   <= oob_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign RDATA     = rdata_q;
  assign RVALID    = rvalid_q;
  assign front_sel = front_sel_q;
  assign frame_cnt = frame_cnt_q;
  assign coll_err  = coll_err_q;
  assign oob_err   = oob_err_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_responder.sv
`default_nettype none
// ============================================================================
//  tb_vram_responder : scoreboard bench for vram_responder.
//  Revision          : 1.0
// ============================================================================
module tb_vram_responder;

  localparam int FB_DEPTH = 307200;

  logic        clk = 1'b0;
  logic        Reset;
  logic        vsync;
  logic        RE;
  logic        WE;
  logic [25:0] ADDR;
  logic [7:0]  WDATA;
  logic        err_clr;
  logic [7:0]  RDATA;
  logic        RVALID;
  logic        front_sel;
  logic [7:0]  frame_cnt;
  logic        coll_err;
  logic        oob_err;
  logic        proto_err;

  vram_responder dut (
    .clk(clk), .Reset(Reset), .vsync(vsync), .RE(RE), .WE(WE),
    .ADDR(ADDR), .WDATA(WDATA), .err_clr(err_clr),
    .RDATA(RDATA), .RVALID(RVALID), .front_sel(front_sel),
    .frame_cnt(frame_cnt), .coll_err(coll_err), .oob_err(oob_err),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] mdl [int];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fails = 0;
  int         n_rv = 0;
  logic [7:0] last_data = 8'd0;
  logic       exp_front;
  logic [7:0] exp_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [25:0] mk(input logic b, input int off);
    return {6'd0, b, off[18:0]};
  endfunction

  function automatic int key(input logic b, input logic [18:0] off);
    return int'({12'd0, b, off});
  endfunction

  function automatic logic [7:0] exp_rd(input logic b, input logic [18:0] off);
    if (int'(off) >= FB_DEPTH) return 8'd0;
    if (mdl.exists(key(b, off))) return mdl[key(b, off)];
    return 8'd0;
  endfunction

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic re, input logic we, input logic [25:0] addr,
                     input logic [7:0] wd, input logic clr);
    exp_t e;
    RE = re; WE = we; ADDR = addr; WDATA = wd; err_clr = clr;
    if (we && int'(addr[18:0]) < FB_DEPTH) mdl[key(addr[19], addr[18:0])] = wd;
    if (re && !we) begin
      e.data = exp_rd(addr[19], addr[18:0]);
      e.due  = cyc + 2;
      sbq.push_back(e);
    end
    idle();
    RE = 1'b0; WE = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sbq.size() > 0; i++) idle();
    idle();
    check_eq("drain_empty", sbq.size(), 0);
  endtask

  task automatic check_flags(input string tag, input logic c, input logic o, input logic p);
    check_eq({tag, "_coll"},  coll_err,  c);
    check_eq({tag, "_oob"},   oob_err,   o);
    check_eq({tag, "_proto"}, proto_err, p);
  endtask

  // Every RVALID must match the head of the scoreboard, in value and in cycle.
  always @(negedge clk) begin
    if (RVALID) begin
      if (sbq.size() == 0) begin
        check_eq("rvalid_unexpected", RVALID, 1'b0);
      end else begin
        mon_e = sbq.pop_front();
        check_eq("rdata", RDATA, mon_e.data);
        check_eq("rd_latency", cyc, mon_e.due);
        last_data = mon_e.data;
        n_rv++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    Reset = 1'b0; vsync = 1'b0; RE = 1'b0; WE = 1'b0;
    ADDR = '0; WDATA = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rvalid", RVALID, 0);
    check_eq("rst_rdata", RDATA, 0);
    check_eq("rst_front", front_sel, 0);
    check_eq("rst_frame", frame_cnt, 0);
    check_flags("rst", 0, 0, 0);
    Reset = 1'b1;
    idle();

    // Dirty every piece of state, then reset with two reads in flight.
    req(0, 1, mk(0, 1), 8'h5A, 0);
    req(1, 1, mk(0, 2), 8'h6B, 0);
    vsync = 1'b1; idle(); vsync = 1'b0; idle();
    check_eq("pre_front", front_sel, 1);
    check_eq("pre_frame", frame_cnt, 1);
    check_flags("pre", 1, 0, 1);
    RE = 1'b1; ADDR = mk(0, 1);
    idle();
    ADDR = mk(0, 2);
    #2;
    Reset = 1'b0; RE = 1'b0;
    #1;
    check_eq("flush_rvalid0", RVALID, 0);
    idle();
    check_eq("flush_rvalid1", RVALID, 0);
    Reset = 1'b1;
    idle();
    check_eq("flush_rvalid2", RVALID, 0);
    idle();
    check_eq("flush_rvalid3", RVALID, 0);
    check_eq("flush_front", front_sel, 0);
    check_eq("flush_frame", frame_cnt, 0);
    check_flags("flush", 0, 0, 0);
    exp_front = 1'b0; exp_cnt = 8'd0;
    req(1, 0, mk(0, 1), 8'h00, 0);
    drain();

    // Write then read back with write-first hazard, bank separation, high bits ignored.
    req(0, 1, mk(0, 5), 8'h3C, 0);
    req(0, 1, mk(1, 5), 8'hA7, 0);
    req(1, 0, mk(1, 5), 8'h00, 0);
    req(1, 0, mk(0, 5), 8'h00, 0);
    req(1, 0, mk(1, 5) | 26'h3F00000, 8'h00, 0);
    drain();
    check_eq("rdata_hold", RDATA, last_data);

    n0 = n_rv;
    for (int i = 0; i < 640; i++) begin
      req(0, 1, mk(1, i), 8'((i * 7 + 3) & 255), 0);
      req(1, 0, mk(1, i), 8'h00, 0);
    end
    drain();
    check_eq("stream_count", n_rv - n0, 640);

    vsync = 1'b1;
    repeat (5) idle();
    vsync = 1'b0;
    idle();
    exp_front = ~exp_front; exp_cnt = exp_cnt + 8'd1;
    check_eq("swap_front", front_sel, exp_front);
    check_eq("swap_frame", frame_cnt, exp_cnt);

    // A read issued alongside the swap still comes from its own bank.
    req(0, 1, mk(0, 9), 8'h11, 0);
    req(0, 1, mk(1, 9), 8'h22, 0);
    vsync = 1'b1;
    req(1, 0, mk(1, 9), 8'h00, 0);
    vsync = 1'b0;
    idle();
    exp_front = ~exp_front; exp_cnt = exp_cnt + 8'd1;
    check_eq("swap2_front", front_sel, exp_front);
    drain();

    for (int i = 0; i < 254; i++) begin
      vsync = 1'b1; idle(); vsync = 1'b0; idle();
      exp_front = ~exp_front; exp_cnt = exp_cnt + 8'd1;
      check_eq("loop_frame", frame_cnt, exp_cnt);
      check_eq("loop_front", front_sel, exp_front);
    end
    check_eq("wrap_frame", frame_cnt, 0);
    check_eq("wrap_front", front_sel, 0);

    // Error flags; front is bank 0 here so bank 1 is the back bank.
    req(0, 0, mk(0, 0), 8'h00, 1);
    check_flags("clr0", 0, 0, 0);
    req(0, 1, mk(1, 100), 8'h55, 0);
    check_flags("back_wr", 0, 0, 0);
    req(0, 1, mk(1, 307199), 8'h66, 0);
    req(0, 1, mk(1, 307200), 8'hFF, 0);
    check_flags("oob_wr", 0, 1, 0);
    idle();
    check_eq("oob_sticky", oob_err, 1);
    req(1, 0, mk(1, 307199), 8'h00, 0);
    req(1, 0, mk(1, 307200), 8'h00, 0);
    req(1, 0, mk(1, 100), 8'h00, 0);
    drain();

    req(0, 0, mk(0, 0), 8'h00, 1);
    req(0, 1, mk(0, 200), 8'h77, 0);
    check_flags("coll", 1, 0, 0);
    req(1, 0, mk(0, 200), 8'h00, 0);
    drain();

    req(0, 0, mk(0, 0), 8'h00, 1);
    req(1, 1, mk(1, 300), 8'h99, 0);
    check_flags("proto", 0, 0, 1);
    idle();
    check_eq("proto_no_rvalid", RVALID, 0);
    req(1, 0, mk(1, 300), 8'h00, 0);
    drain();

    req(0, 0, mk(0, 0), 8'h00, 1);
    req(0, 1, mk(1, 400000), 8'hEE, 1);
    check_flags("clr_set_wins", 0, 1, 0);
    req(0, 0, mk(0, 0), 8'h00, 1);
    check_flags("clr_alone", 0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
